// File: rtl/proc_pkg.sv
// Shared encodings for the accumulator processor controller: opcodes, FSM states,
// instruction classes and ACC mux selects.
package proc_pkg;

    localparam int unsigned OpcodeBits = 4;

    // ALU-class opcodes double as the ALU select codes.
    typedef enum logic [3:0] {
        OpNop    = 4'd0,
        OpAdd    = 4'd1,
        OpSub    = 4'd2,
        OpNor    = 4'd3,
        OpLoadr  = 4'd4,
        OpStorr  = 4'd5,
        OpLoadi  = 4'd6,
        OpJmp    = 4'd7,
        OpJz     = 4'd8,
        OpJc     = 4'd9,
        OpRsvd10 = 4'd10,
        OpShfr   = 4'd11,
        OpShfl   = 4'd12,
        OpRsvd13 = 4'd13,
        OpRsvd14 = 4'd14,
        OpHalt   = 4'd15
    } opcode_e;

    typedef enum logic [2:0] {
        StReset  = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StAlu    = 3'd3,
        StMov    = 3'd4,
        StImm    = 3'd5,
        StHalt   = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        ClsNop,
        ClsAlu,
        ClsMov,
        ClsImm,
        ClsHalt,
        ClsRsvd
    } instr_class_e;

    localparam logic [1:0] AccSelAlu = 2'b00;
    localparam logic [1:0] AccSelReg = 2'b01;
    localparam logic [1:0] AccSelImm = 2'b10;

endpackage

// File: rtl/proc_controller_if.sv
// Control bus between the processor controller (master) and the datapath (slave).
interface proc_controller_if;
    import proc_pkg::*;

    logic [OpcodeBits-1:0] ir_opcode;
    logic                  alu_zero_flag;
    logic                  alu_carry_out;
    logic [3:0]            alu_select;
    logic                  ir_load;
    logic                  pc_inc;
    logic                  pc_load;
    logic                  acc_load;
    logic [1:0]            acc_sel;
    logic                  reg_load;
    logic                  flag_z;
    logic                  flag_c;
    logic                  halted;
    logic [2:0]            ctrl_state;

    modport master (
        input  ir_opcode, alu_zero_flag, alu_carry_out,
        output alu_select, ir_load, pc_inc, pc_load, acc_load, acc_sel, reg_load,
        output flag_z, flag_c, halted, ctrl_state
    );

    modport slave (
        output ir_opcode, alu_zero_flag, alu_carry_out,
        input  alu_select, ir_load, pc_inc, pc_load, acc_load, acc_sel, reg_load,
        input  flag_z, flag_c, halted, ctrl_state
    );

endinterface

// File: rtl/proc_ctrl_decode.sv
// Combinational opcode to instruction-class decode consumed by the controller FSM.
module proc_ctrl_decode
    import proc_pkg::*;
(
    input  logic [OpcodeBits-1:0] opcode,
    output instr_class_e          instr_class
);

    always_comb begin
        instr_class = ClsRsvd;
        unique case (opcode_e'(opcode))
            OpNop:                             instr_class = ClsNop;
            OpAdd, OpSub, OpNor, OpShfr, OpShfl: instr_class = ClsAlu;
            OpLoadr, OpStorr:                  instr_class = ClsMov;
            OpLoadi, OpJmp, OpJz, OpJc:        instr_class = ClsImm;
            OpHalt:                            instr_class = ClsHalt;
            default:                           instr_class = ClsRsvd;
        endcase
    end

endmodule

// File: rtl/proc_controller.sv
// Multi-cycle fetch/decode/execute controller for the 8-bit accumulator processor.
// Only the state and the Z/C flags are registered; strobes decode from state and opcode.
module proc_controller
    import proc_pkg::*;
#(
    parameter int unsigned OPCODE_W         = 4,
    parameter bit          HALT_ON_RESERVED = 1'b0
) (
    input logic              clk,
    input logic              rst,
    proc_controller_if.master bus
);

    logic [OPCODE_W-1:0] opcode;
    instr_class_e        instr_class;
    state_e              state_q, state_d;
    logic                flag_z_q, flag_c_q;

    assign opcode = bus.ir_opcode;

    proc_ctrl_decode u_decode (
        .opcode      (opcode),
        .instr_class (instr_class)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StReset:  state_d = StFetch;
            StFetch:  state_d = StDecode;
            StDecode: begin
                case (instr_class)
                    ClsAlu:  state_d = StAlu;
                    ClsMov:  state_d = StMov;
                    ClsImm:  state_d = StImm;
                    ClsHalt: state_d = StHalt;
                    ClsRsvd: state_d = HALT_ON_RESERVED ? StHalt : StFetch;
                    default: state_d = StFetch;
                endcase
            end
            StAlu, StMov, StImm: state_d = StFetch;
            StHalt:   state_d = StHalt;
            default:  state_d = StReset;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StReset;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            state_q <= state_d;
            // Flags capture the ALU result on the same edge that loads ACC.
            if (state_q == StAlu) begin
                flag_z_q <= bus.alu_zero_flag;
                flag_c_q <= bus.alu_carry_out;
            end
        end
    end

    always_comb begin
        bus.alu_select = 4'b0000;
        bus.ir_load    = 1'b0;
        bus.pc_inc     = 1'b0;
        bus.pc_load    = 1'b0;
        bus.acc_load   = 1'b0;
        bus.acc_sel    = AccSelAlu;
        bus.reg_load   = 1'b0;
        bus.halted     = 1'b0;
        case (state_q)
            StFetch: begin
                bus.ir_load = 1'b1;
                bus.pc_inc  = 1'b1;
            end
            StAlu: begin
                bus.alu_select = opcode;
                bus.acc_sel    = AccSelAlu;
                bus.acc_load   = 1'b1;
            end
            StMov: begin
                if (opcode_e'(opcode) == OpLoadr) begin
                    bus.acc_sel  = AccSelReg;
                    bus.acc_load = 1'b1;
                end else if (opcode_e'(opcode) == OpStorr) begin
                    bus.reg_load = 1'b1;
                end
            end
            StImm: begin
                // Untaken conditional jumps still step PC past the target byte.
                case (opcode_e'(opcode))
                    OpLoadi: begin
                        bus.acc_sel  = AccSelImm;
                        bus.acc_load = 1'b1;
                        bus.pc_inc   = 1'b1;
                    end
                    OpJmp: bus.pc_load = 1'b1;
                    OpJz: begin
                        bus.pc_load = flag_z_q;
                        bus.pc_inc  = ~flag_z_q;
                    end
                    OpJc: begin
                        bus.pc_load = flag_c_q;
                        bus.pc_inc  = ~flag_c_q;
                    end
                    default: ;
                endcase
            end
            StHalt:  bus.halted = 1'b1;
            default: ;
        endcase
    end

    assign bus.flag_z     = flag_z_q;
    assign bus.flag_c     = flag_c_q;
    assign bus.ctrl_state = state_q;

endmodule

// File: tb/tb_proc_controller.sv
// Directed self-checking bench for proc_controller; a second instance has
// HALT_ON_RESERVED=1 to cover reserved-opcode halting.
module tb_proc_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] opcode = 4'd1;
    logic       zin = 1'b1;
    logic       cin = 1'b1;

    int checks = 0;
    int errors = 0;

    proc_controller_if bus0 ();
    proc_controller_if bus1 ();

    assign bus0.ir_opcode     = opcode;
    assign bus0.alu_zero_flag = zin;
    assign bus0.alu_carry_out = cin;
    assign bus1.ir_opcode     = opcode;
    assign bus1.alu_zero_flag = zin;
    assign bus1.alu_carry_out = cin;

    proc_controller #(.OPCODE_W(4), .HALT_ON_RESERVED(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    proc_controller #(.OPCODE_W(4), .HALT_ON_RESERVED(1'b1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    // {ir_load, pc_inc, pc_load, acc_load, reg_load}
    logic [4:0] strb0, strb1;
    assign strb0 = {bus0.ir_load, bus0.pc_inc, bus0.pc_load, bus0.acc_load, bus0.reg_load};
    assign strb1 = {bus1.ir_load, bus1.pc_inc, bus1.pc_load, bus1.acc_load, bus1.reg_load};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        step();
        step();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2;
        // Reset state
        check("rst_state", bus0.ctrl_state, 0);
        check("rst_strobes", strb0, 5'b00000);
        check("rst_flags", {bus0.flag_z, bus0.flag_c}, 2'b00);
        check("rst_misc", {bus0.alu_select, bus0.acc_sel, bus0.halted}, 7'b0);
        step();
        check("rst_held_state", bus0.ctrl_state, 0);
        @(negedge clk);
        rst = 1'b0;

        // ADD with Z=1, C=1
        step();
        check("add_fetch_state", bus0.ctrl_state, 1);
        check("add_fetch_strb", strb0, 5'b11000);
        step();
        check("add_decode_state", bus0.ctrl_state, 2);
        check("add_decode_strb", strb0, 5'b00000);
        step();
        check("add_alu_state", bus0.ctrl_state, 3);
        check("add_alu_strb", strb0, 5'b00010);
        check("add_alu_sel", {bus0.alu_select, bus0.acc_sel}, {4'b0001, 2'b00});
        check("add_flags_before", {bus0.flag_z, bus0.flag_c}, 2'b00);
        step();
        check("add_back_fetch", bus0.ctrl_state, 1);
        check("add_flags_after", {bus0.flag_z, bus0.flag_c}, 2'b11);
        check("add_alu_sel_idle", bus0.alu_select, 4'b0000);

        // STORR; flag inputs low must not disturb latched flags
        opcode = 4'b0101; zin = 1'b0; cin = 1'b0;
        step();
        step();
        check("storr_state", bus0.ctrl_state, 4);
        check("storr_strb", strb0, 5'b00001);
        step();
        check("storr_back_fetch", bus0.ctrl_state, 1);
        check("storr_flags", {bus0.flag_z, bus0.flag_c}, 2'b11);

        // JZ taken
        opcode = 4'b1000;
        step();
        step();
        check("jz_t_state", bus0.ctrl_state, 5);
        check("jz_t_strb", strb0, 5'b00100);
        step();

        // SUB clears flags
        opcode = 4'b0010;
        step();
        step();
        check("sub_alu_sel", bus0.alu_select, 4'b0010);
        step();
        check("sub_flags", {bus0.flag_z, bus0.flag_c}, 2'b00);

        // JZ not taken, JC not taken
        opcode = 4'b1000;
        step();
        step();
        check("jz_nt_strb", strb0, 5'b01000);
        step();
        opcode = 4'b1001;
        step();
        step();
        check("jc_nt_strb", strb0, 5'b01000);
        step();

        // LOADI
        opcode = 4'b0110;
        step();
        step();
        check("loadi_state", bus0.ctrl_state, 5);
        check("loadi_strb", strb0, 5'b01010);
        check("loadi_accsel", bus0.acc_sel, 2'b10);
        step();

        // NOP: two-cycle latency
        opcode = 4'b0000;
        step();
        check("nop_decode", bus0.ctrl_state, 2);
        step();
        check("nop_back_fetch", bus0.ctrl_state, 1);

        // Reserved 1101
        opcode = 4'b1101;
        step();
        check("rsv_decode_strb", strb0, 5'b00000);
        step();
        check("rsv0_fetch", bus0.ctrl_state, 1);
        check("rsv1_halt", bus1.ctrl_state, 6);
        for (int i = 0; i < 10; i++) begin
            check("rsv1_halted", {bus1.halted, bus1.ctrl_state, strb1}, {1'b1, 3'd6, 5'b0});
            step();
        end

        // HALT opcode
        do_reset();
        opcode = 4'b1111;
        step();
        step();
        step();
        for (int i = 0; i < 20; i++) begin
            check("halt_hold", {bus0.halted, bus0.ctrl_state, strb0}, {1'b1, 3'd6, 5'b0});
            step();
        end

        // Async reset during ALU state of SUB
        do_reset();
        opcode = 4'b0010; zin = 1'b1; cin = 1'b1;
        step();
        step();
        step();
        step();
        check("sub2_flags", {bus0.flag_z, bus0.flag_c}, 2'b11);
        step();
        step();
        check("sub2_alu_state", bus0.ctrl_state, 3);
        #2;
        rst = 1'b1;
        #1;
        check("async_state", bus0.ctrl_state, 0);
        check("async_flags", {bus0.flag_z, bus0.flag_c}, 2'b00);
        check("async_outs", {strb0, bus0.alu_select, bus0.acc_sel, bus0.halted}, 12'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
